// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arb
// Description : Round-robin, message-atomic arbiter that shares one UART
//               write channel between NUM_REQ byte-stream requesters.
//               Define UART_ARB_TAG_EN to prefix each message with a
//               source tag byte (TAG_BASE + requester index).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arb #(
    parameter int         NUM_REQ  = 4,
    parameter logic [7:0] TAG_BASE = 8'hF0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             uart_wr_data,
    output logic                   uart_wr_valid,
    input  logic                   uart_wr_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy
);

    localparam int IDXW = $clog2(NUM_REQ);

`ifdef UART_ARB_TAG_EN
    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, TAG = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1} state_t;
    logic [7:0] tag_unused;
    assign tag_unused = TAG_BASE;
`endif

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IDXW-1:0]     gidx_q, gidx_d;
    logic [IDXW-1:0]     rr_ptr_q, rr_ptr_d;

    logic [7:0]          data_arr [NUM_REQ];
    logic                pick_found;
    logic [IDXW-1:0]     pick_idx;
    int unsigned         cand;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign data_arr[gi] = req_data[8*gi +: 8];
    end

    // Scan from farthest to nearest so the nearest requester after rr_ptr wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = (32'(rr_ptr_q) + 32'(k)) % NUM_REQ;
            if (req_valid[IDXW'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IDXW'(cand);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= IDXW'(NUM_REQ - 1);
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        gidx_d        = gidx_q;
        rr_ptr_d      = rr_ptr_q;
        uart_wr_valid = 1'b0;
        uart_wr_data  = 8'h00;
        req_ready     = '0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    gidx_d  = pick_idx;
`ifdef UART_ARB_TAG_EN
                    state_d = TAG;
`else
                    state_d = XFER;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            TAG: begin
                uart_wr_valid = 1'b1;
                uart_wr_data  = TAG_BASE + 8'(gidx_q);
                if (uart_wr_ready) begin
                    state_d = XFER;
                end
            end
`endif
            XFER: begin
                uart_wr_valid     = req_valid[gidx_q];
                uart_wr_data      = data_arr[gidx_q];
                req_ready[gidx_q] = uart_wr_ready;
                if (req_valid[gidx_q] && uart_wr_ready && req_last[gidx_q]) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = gidx_q;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign grant = grant_q;
    assign busy  = (state_q != IDLE);

endmodule
`default_nettype wire
